diag_capture: RTL and testbench
===============================

# diag_capture

Diagnostic-port capture engine sitting directly downstream of the system controller's diag-selection registers. Multiplexes one 32-bit group from a wide diagnostic bus onto the external diag port and, on a software trigger, snapshots the selected group after a programmable delay. The snapshot is returned to the register bank as the read-back value of the diag value register.

## Interface
Parameters:
- NUM_GROUPS, 8: number of 32-bit diagnostic groups on diag_groups (1..256).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- diag_sel_en  in  1  block enable, from diag-selection register bit 31.
- diag_sel  in  16  [7:0] group index, [15:8] post-trigger delay D in cycles.
- diag_trigger  in  1  software trigger level, from diag trigger register bit 0.
- diag_groups  in  NUM_GROUPS*32  group g occupies bits [32g+31:32g].
- diag_port  out  32  registered live mux output to pins.
- diag_value  out  32  captured snapshot, to register read-back.
- diag_done  out  1  snapshot valid.

## Operation
- Mux: sel_grp = selected group if diag_sel[7:0] < NUM_GROUPS, else 32'h0. Registered into diag_port every cycle while diag_sel_en=1; diag_port forced to 0 when diag_sel_en=0.
- Edge detect: trig_q <= diag_trigger each cycle (reset 0); rise = diag_trigger & ~trig_q. A trigger already high at reset release counts as a rise.
- FSM states IDLE, DELAY, HOLD:
  - IDLE: on rise with diag_sel_en=1 -> DELAY, cnt <= diag_sel[15:8], diag_done <= 0.
  - DELAY: if diag_trigger=0 -> IDLE (abort, diag_value unchanged, diag_done stays 0). Else if cnt=0 -> diag_value <= diag_port, diag_done <= 1, -> HOLD. Else cnt <= cnt-1.
  - HOLD: diag_trigger=0 -> IDLE; diag_done and diag_value retained.
- diag_sel_en=0 in any state -> IDLE next cycle, diag_done <= 0, cnt <= 0; diag_value retained.
- diag_sel changes during DELAY take effect on the mux immediately; the delay count already loaded is not reloaded.
- cnt is 8 bits, decrement only, no wrap (exits at 0).
- Re-trigger requires trigger low then high; a rise is only possible in IDLE.

## Timing
- Reset values: diag_port 0, diag_value 0, diag_done 0, state IDLE, cnt 0, trig_q 0.
- diag_port latency: 1 cycle from diag_groups/diag_sel (3 with sync, see Configuration).
- Rise detected at edge Tdet (first edge sampling diag_trigger=1 with trig_q=0): FSM in DELAY after Tdet.
- Capture edge = Tdet+1+D; diag_value equals the diag_port value registered at edge Tdet+D (input group as sampled at Tdet+D); diag_done high from the same edge.
- D=0: capture at Tdet+1. D=255: capture at Tdet+256.
- Abort: trigger low sampled at any DELAY edge up to and including the capture edge wins over capture.

## Configuration
- RW_DIAG_SYNC_EN defined: diag_groups passes through a two-flop synchronizer (reset 0) before the mux; diag_port latency 3 cycles, capture samples input at edge Tdet+D-2 equivalently. Use for asynchronous diag sources.
- Undefined: no synchronizer, latency 1 cycle as above.

## Test plan
- Reset: assert rst_n=0 mid-DELAY -> all outputs 0, state IDLE immediately; after release with trigger held 1 and en=1 -> rise detected, capture proceeds.
- Mux: NUM_GROUPS=8, groups g=32'hA000_000g, en=1, sel[7:0]=5 -> diag_port=32'hA000_0005 one cycle later; sel=9 -> 0; en=0 -> 0.
- Capture D=0: sel=16'h0003, pulse trigger high and hold -> diag_value=32'hA000_0003, diag_done=1 exactly 1 cycle after detection edge.
- Capture D=10 with group 3 driven by free-running counter -> diag_value equals counter value sampled at Tdet+10, done at Tdet+11.
- Abort: D=20, drop trigger after 5 cycles -> FSM IDLE, diag_done=0, diag_value unchanged; re-raise -> new capture completes.
- Enable drop in HOLD: en 1->0 -> diag_done=0 next cycle, diag_value retained, diag_port=0; with RW_DIAG_SYNC_EN, repeat D=0 test -> diag_port latency 3 cycles.

Source files
------------

// File: rtl/diag_capture.sv
// Diagnostic-port capture engine: muxes one 32-bit group of a wide diag bus onto
// the external diag port and, on a software trigger edge, snapshots the selected
// group after a programmable delay for register read-back.
//
// Ports:
//   clk, rst_n         system clock, asynchronous active-low reset
//   diag_sel_en        block enable; low forces the port to 0 and the FSM to IDLE
//   diag_sel           [7:0] group index, [15:8] post-trigger delay D in cycles
//   diag_trigger       software trigger level (a rising edge arms a capture)
//   diag_groups        NUM_GROUPS x 32-bit groups, group g at [32g+31:32g]
//   diag_port          registered live mux output (0 for out-of-range index)
//   diag_value         captured snapshot
//   diag_done          snapshot valid
//
// Optional feature: define RW_DIAG_SYNC_EN to pass diag_groups through a
// two-flop synchronizer before the mux (port latency 3 instead of 1).

module diag_capture #(
    parameter int NUM_GROUPS = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       diag_sel_en,
    input  logic [15:0]                diag_sel,
    input  logic                       diag_trigger,
    input  logic [NUM_GROUPS*32-1:0]   diag_groups,
    output logic [31:0]                diag_port,
    output logic [31:0]                diag_value,
    output logic                       diag_done
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DELAY,
        ST_HOLD
    } state_t;

    state_t             state_q;
    logic [7:0]         cnt_q;
    logic               trig_q;
    logic [31:0]        port_q;
    logic [31:0]        port_d;
    logic [31:0]        value_q;
    logic               done_q;
    logic [31:0]        sel_grp;
    logic               rise;
    logic [NUM_GROUPS*32-1:0] grp_src;

`ifdef RW_DIAG_SYNC_EN
    // Two-flop synchronizer for asynchronous diag sources.
    logic [NUM_GROUPS*32-1:0] sync1_q;
    logic [NUM_GROUPS*32-1:0] sync2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= diag_groups;
            sync2_q <= sync1_q;
        end
    end

    assign grp_src = sync2_q;
`else
    assign grp_src = diag_groups;
`endif

    // Index compare against every implemented group; an index at or above
    // NUM_GROUPS matches nothing and leaves the default of zero.
    always_comb begin
        sel_grp = '0;
        for (int g = 0; g < NUM_GROUPS; g++) begin
            if (diag_sel[7:0] == 8'(g)) begin
                sel_grp = grp_src[g*32 +: 32];
            end
        end
    end

    assign port_d = diag_sel_en ? sel_grp : 32'h0;

    // trig_q resets to 0, so a trigger already high at reset release is a rise.
    assign rise = diag_trigger & ~trig_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            port_q <= '0;
            trig_q <= 1'b0;
        end else begin
            port_q <= port_d;
            trig_q <= diag_trigger;
        end
    end

    // Capture FSM. Disable has priority over every state; the snapshot itself
    // is only ever overwritten by a completed capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            value_q <= '0;
            done_q  <= 1'b0;
        end else if (!diag_sel_en) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (rise) begin
                        state_q <= ST_DELAY;
                        cnt_q   <= diag_sel[15:8];
                        done_q  <= 1'b0;
                    end
                end
                ST_DELAY: begin
                    // A dropped trigger aborts even on the would-be capture edge.
                    if (!diag_trigger) begin
                        state_q <= ST_IDLE;
                    end else if (cnt_q == 8'd0) begin
                        value_q <= port_q;
                        done_q  <= 1'b1;
                        state_q <= ST_HOLD;
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                ST_HOLD: begin
                    if (!diag_trigger) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign diag_port  = port_q;
    assign diag_value = value_q;
    assign diag_done  = done_q;

endmodule

// File: tb/tb_diag_capture.sv
// Scoreboard bench for diag_capture: stimulus pushes cycle-stamped expectations
// for port/value/done plus expected capture events; an independent monitor pops
// and compares them at the falling edge.

module tb_diag_capture;

    localparam int NG = 8;
`ifdef RW_DIAG_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    localparam int K_PORT  = 0;
    localparam int K_VALUE = 1;
    localparam int K_DONE  = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              diag_sel_en = 1'b0;
    logic [15:0]       diag_sel = 16'h0;
    logic              diag_trigger = 1'b0;
    logic [NG*32-1:0]  diag_groups = '0;
    logic [31:0]       diag_port;
    logic [31:0]       diag_value;
    logic              diag_done;

    diag_capture #(.NUM_GROUPS(NG)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .diag_sel_en  (diag_sel_en),
        .diag_sel     (diag_sel),
        .diag_trigger (diag_trigger),
        .diag_groups  (diag_groups),
        .diag_port    (diag_port),
        .diag_value   (diag_value),
        .diag_done    (diag_done)
    );

    always #5 clk = ~clk;

    // Number of rising edges seen so far; stable while sampling at the falling edge.
    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    typedef struct {
        int          at;
        int          kind;
        logic [31:0] exp;
    } exp_t;

    typedef struct {
        int          at;
        logic [31:0] val;
    } cap_t;

    exp_t sb_q[$];
    cap_t cap_q[$];

    int n_vec = 0;
    int n_bad = 0;
    logic done_prev = 1'b0;
    bit   cnt_mode = 1'b0;

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %h, want %h", nm, cyc, act, exp);
        end
    endtask

    function automatic string kname(input int k);
        if (k == K_PORT)  return "diag_port";
        if (k == K_VALUE) return "diag_value";
        return "diag_done";
    endfunction

    // Monitor: level checks due this cycle, then capture events on done rise.
    always @(negedge clk) begin
        for (int i = sb_q.size() - 1; i >= 0; i--) begin
            if (sb_q[i].at == cyc) begin
                case (sb_q[i].kind)
                    K_PORT:  cmp(kname(K_PORT),  diag_port,  sb_q[i].exp);
                    K_VALUE: cmp(kname(K_VALUE), diag_value, sb_q[i].exp);
                    default: cmp(kname(K_DONE),  {31'h0, diag_done}, sb_q[i].exp);
                endcase
                sb_q.delete(i);
            end
        end
        if (diag_done && !done_prev) begin
            if (cap_q.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_capture @cyc %0d: got value %h, want no capture", cyc, diag_value);
            end else begin
                cap_t c;
                c = cap_q.pop_front();
                cmp("capture_value", diag_value, c.val);
                cmp("capture_cycle", 32'(cyc), 32'(c.at));
            end
        end
        done_prev = diag_done;
    end

    task automatic set_grp(input int g, input logic [31:0] v);
        diag_groups[g*32 +: 32] = v;
    endtask

    // Advance to the next falling edge; optionally run group 3 as a cycle counter.
    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (cnt_mode) set_grp(3, 32'hC000_0000 + 32'(cyc));
        end
    endtask

    task automatic expect_at(input int kind, input int dc, input logic [31:0] e);
        exp_t x;
        x.at = cyc + dc;
        x.kind = kind;
        x.exp = e;
        sb_q.push_back(x);
    endtask

    task automatic expect_cap(input int dc, input logic [31:0] v);
        cap_t c;
        c.at = cyc + dc;
        c.val = v;
        cap_q.push_back(c);
    endtask

    logic [31:0] last_val;

    initial begin
        for (int g = 0; g < NG; g++) set_grp(g, 32'hA000_0000 + 32'(g));
        rst_n = 1'b0;
        tick(2);

        // Reset state.
        rst_n = 1'b1;
        expect_at(K_PORT, 1, 32'h0);
        expect_at(K_VALUE, 1, 32'h0);
        expect_at(K_DONE, 1, 32'h0);
        tick();

        // Mux: in range, out of range, disabled, re-enabled.
        diag_sel_en = 1'b1;
        diag_sel = 16'h0005;
        expect_at(K_PORT, 1, 32'hA000_0005);
        tick();
        diag_sel = 16'h0009;
        expect_at(K_PORT, 1, 32'h0);
        tick();
        diag_sel = 16'h0005;
        diag_sel_en = 1'b0;
        expect_at(K_PORT, 1, 32'h0);
        tick();
        diag_sel_en = 1'b1;
        diag_sel = 16'h0007;
        expect_at(K_PORT, 1, 32'hA000_0007);
        tick();

        // Group-to-port latency: a one-cycle pulse on group 3.
        diag_sel = 16'h0003;
        tick(4);
        set_grp(3, 32'h5555_0003);
        expect_at(K_PORT, LAT, 32'h5555_0003);
        expect_at(K_PORT, LAT + 1, 32'hA000_0003);
        tick();
        set_grp(3, 32'hA000_0003);
        tick(LAT + 3);

        // Capture with D=0.
        diag_trigger = 1'b1;
        expect_at(K_DONE, 1, 32'h0);
        expect_at(K_DONE, 2, 32'h1);
        expect_at(K_VALUE, 2, 32'hA000_0003);
        expect_cap(2, 32'hA000_0003);
        tick(4);
        diag_trigger = 1'b0;
        expect_at(K_DONE, 1, 32'h1);
        expect_at(K_VALUE, 1, 32'hA000_0003);
        tick(2);

        // Capture with D=10 on a free-running counter in group 3.
        cnt_mode = 1'b1;
        diag_sel = 16'h0A03;
        tick(3);
        diag_trigger = 1'b1;
        // Detection edge is cyc+1; port at edge E holds counter driven before edge E-LAT+1.
        last_val = 32'hC000_0000 + 32'(cyc + 1 + 10 - LAT);
        expect_at(K_DONE, 1, 32'h0);
        expect_at(K_DONE, 11, 32'h0);
        expect_at(K_DONE, 12, 32'h1);
        expect_at(K_VALUE, 12, last_val);
        expect_cap(12, last_val);
        tick(14);
        diag_trigger = 1'b0;
        cnt_mode = 1'b0;
        set_grp(3, 32'hA000_0003);
        tick(2);

        // Abort: D=20, trigger dropped after 5 cycles.
        diag_sel = 16'h1403;
        diag_trigger = 1'b1;
        expect_at(K_DONE, 1, 32'h0);
        tick(5);
        diag_trigger = 1'b0;
        expect_at(K_DONE, 20, 32'h0);
        expect_at(K_VALUE, 20, last_val);
        tick(22);

        // Re-raise: new capture completes.
        diag_trigger = 1'b1;
        expect_at(K_DONE, 21, 32'h0);
        expect_at(K_DONE, 22, 32'h1);
        expect_at(K_VALUE, 22, 32'hA000_0003);
        expect_cap(22, 32'hA000_0003);
        tick(24);

        // Enable drop in HOLD.
        diag_sel_en = 1'b0;
        expect_at(K_DONE, 1, 32'h0);
        expect_at(K_PORT, 1, 32'h0);
        expect_at(K_VALUE, 1, 32'hA000_0003);
        expect_at(K_VALUE, 2, 32'hA000_0003);
        tick(2);
        // Re-enable with trigger still high: no edge, so no new capture.
        diag_sel_en = 1'b1;
        expect_at(K_DONE, 5, 32'h0);
        tick(6);

        // Reset mid-DELAY, then trigger held high through release.
        diag_trigger = 1'b0;
        tick();
        diag_sel = 16'h0805;
        diag_trigger = 1'b1;
        tick(3);
        rst_n = 1'b0;
        expect_at(K_PORT, 1, 32'h0);
        expect_at(K_VALUE, 1, 32'h0);
        expect_at(K_DONE, 1, 32'h0);
        tick();
        rst_n = 1'b1;
        expect_at(K_DONE, 9, 32'h0);
        expect_at(K_DONE, 10, 32'h1);
        expect_at(K_VALUE, 10, 32'hA000_0005);
        expect_cap(10, 32'hA000_0005);
        tick(12);

        tick(2);
        foreach (sb_q[i]) begin
            n_vec++;
            n_bad++;
            $display("FAIL %s_unchecked: due cyc %0d never reached, want %h", kname(sb_q[i].kind), sb_q[i].at, sb_q[i].exp);
        end
        foreach (cap_q[i]) begin
            n_vec++;
            n_bad++;
            $display("FAIL missing_capture: got none, want value %h at cyc %0d", cap_q[i].val, cap_q[i].at);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
